// File: rtl/adv_timer_capture.sv
// PWM input capture: measures period and active time of an asynchronous input,
// in prescaled ticks, and presents results through a valid/ready handshake.
module adv_timer_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_en_i,
   input  logic             cfg_pol_i,
   input  logic [7:0]       cfg_presc_i,
   input  logic             signal_i,
   input  logic             meas_ready_i,
   output logic             meas_valid_o,
   output logic [CNT_W-1:0] meas_period_o,
   output logic [CNT_W-1:0] meas_high_o,
   output logic             ovf_o,
   input  logic             ovf_clr_i,
   output logic             drop_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   act_q, act_prev_q;
   logic                   pol_q, seen_low_q;
   logic [7:0]             presc_q, pcnt_q;
   logic [CNT_W-1:0]       cnt_q, cnt_now, high_q;
   logic [CNT_W-1:0]       period_res_q, high_res_q;
   logic                   valid_q, drop_q, ovf_q;
   logic                   pol_eff, rise, fall, tick, at_max, measuring;
   logic                   arm_load, clr_cnt, cap_high, publish, ovf_set;

   // While idle the edge register follows the live polarity, so the first ARM
   // cycle already reflects the polarity frozen on arming.
   assign pol_eff   = (state_q == IDLE) ? cfg_pol_i : pol_q;
   assign rise      = act_q & ~act_prev_q;
   assign fall      = ~act_q & act_prev_q;
   assign measuring = (state_q == HIGH) || (state_q == LOW);
   assign tick      = (pcnt_q == presc_q);
   assign at_max    = &cnt_q;
   assign cnt_now   = tick ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q     <= '0;
         act_q      <= 1'b0;
         act_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_i};
         act_q      <= sync_q[SYNC_STAGES-1] ^ pol_eff;
         act_prev_q <= act_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      arm_load = 1'b0;
      clr_cnt  = 1'b0;
      cap_high = 1'b0;
      publish  = 1'b0;
      ovf_set  = 1'b0;
      if (!cfg_en_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = ARM;
               arm_load = 1'b1;
            end
            ARM: begin
               if (rise && seen_low_q) begin
                  state_d = HIGH;
                  clr_cnt = 1'b1;
               end
            end
            HIGH: begin
               if (tick && at_max) begin
                  ovf_set = 1'b1;
                  state_d = ARM;
               end else if (fall) begin
                  cap_high = 1'b1;
                  state_d  = LOW;
               end
            end
            LOW: begin
               if (tick && at_max) begin
                  ovf_set = 1'b1;
                  state_d = ARM;
               end else if (rise) begin
                  publish = 1'b1;
                  clr_cnt = 1'b1;
                  state_d = HIGH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Inactive level must be observed during an earlier ARM cycle before a rise counts.
   always_ff @(posedge clk_i) begin
      if (rst_i) seen_low_q <= 1'b0;
      else       seen_low_q <= (state_q == ARM) && (state_d == ARM) && (seen_low_q || !act_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pol_q   <= 1'b0;
         presc_q <= '0;
      end else if (arm_load) begin
         pol_q   <= cfg_pol_i;
         presc_q <= cfg_presc_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_cnt || !measuring) begin
         cnt_q  <= '0;
         pcnt_q <= '0;
      end else if (tick) begin
         cnt_q  <= cnt_now;
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)         high_q <= '0;
      else if (cap_high) high_q <= cnt_now;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q      <= 1'b0;
         drop_q       <= 1'b0;
         period_res_q <= '0;
         high_res_q   <= '0;
      end else begin
         drop_q <= 1'b0;
         if (publish) begin
            if (valid_q && !meas_ready_i) begin
               drop_q <= 1'b1;
            end else begin
               valid_q      <= 1'b1;
               period_res_q <= cnt_now;
               high_res_q   <= high_q;
            end
         end else if (valid_q && meas_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)          ovf_q <= 1'b0;
      else if (ovf_set)   ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
   end

   assign meas_valid_o  = valid_q;
   assign meas_period_o = period_res_q;
   assign meas_high_o   = high_res_q;
   assign ovf_o         = ovf_q;
   assign drop_o        = drop_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_adv_timer_capture.sv
// Bench for adv_timer_capture: edge-time reference model plus directed
// handshake, overflow, disable and reset scenarios.
module tb_adv_timer_capture;
   localparam int S = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, pol_i, ready, sig, clr;
   logic [7:0]  presc_i;
   logic        valid, ovf, drop, busy;
   logic [15:0] period, high;

   logic        en8, sig8, clr8;
   logic        valid8, ovf8, drop8, busy8;
   logic [7:0]  period8, high8;

   adv_timer_capture dut (
      .clk_i(clk), .rst_i(rst), .cfg_en_i(en), .cfg_pol_i(pol_i), .cfg_presc_i(presc_i),
      .signal_i(sig), .meas_ready_i(ready), .meas_valid_o(valid), .meas_period_o(period),
      .meas_high_o(high), .ovf_o(ovf), .ovf_clr_i(clr), .drop_o(drop), .busy_o(busy)
   );

   adv_timer_capture #(.CNT_W(8), .SYNC_STAGES(S)) dut8 (
      .clk_i(clk), .rst_i(rst), .cfg_en_i(en8), .cfg_pol_i(1'b0), .cfg_presc_i(8'd0),
      .signal_i(sig8), .meas_ready_i(1'b1), .meas_valid_o(valid8), .meas_period_o(period8),
      .meas_high_o(high8), .ovf_o(ovf8), .ovf_clr_i(clr8), .drop_o(drop8), .busy_o(busy8)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ntests = 0, nfail = 0;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: results derived from the times the active level changes.
   typedef struct {int period; int high; int cyc;} res_t;
   res_t q[$];
   res_t mon_e;
   bit   live = 0, seen = 0, open = 0, cur_act = 0, m_pol = 0, mon_en = 0;
   int   r_cyc = 0, f_cyc = 0, m_presc = 0;
   int   nres = 0, drop_cnt = 0;

   task automatic model_arm();
      live = 1;
      seen = !cur_act;
      open = 0;
   endtask

   task automatic drive(input bit a, input int n);
      res_t e;
      if (live && a && !cur_act) begin
         if (seen) begin
            if (open) begin
               e.period = (cyc - r_cyc) / (m_presc + 1);
               e.high   = (f_cyc - r_cyc) / (m_presc + 1);
               e.cyc    = cyc;
               q.push_back(e);
            end
            r_cyc = cyc;
            open  = 1;
         end
      end else if (live && !a && cur_act) begin
         seen  = 1;
         f_cyc = cyc;
      end
      cur_act = a;
      sig     = a ^ m_pol;
      repeat (n) @(negedge clk);
   endtask

   task automatic start(input int p, input bit pl);
      live    = 0;
      en      = 0;
      m_presc = p;
      m_pol   = pl;
      presc_i = 8'(p);
      pol_i   = pl;
      drive(0, S + 4);
      en = 1;
      model_arm();
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (drop) drop_cnt++;
      if (mon_en && valid && ready) begin
         if (q.size() == 0) begin
            check("spurious_valid", valid, 0);
         end else begin
            mon_e = q.pop_front();
            check("period", period, mon_e.period);
            check("high", high, mon_e.high);
            check("latency", cyc - mon_e.cyc, S + 2);
            nres++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, r0, d0;
      rst = 1; en = 0; pol_i = 0; presc_i = 0; ready = 1; sig = 0; clr = 0;
      en8 = 0; sig8 = 0; clr8 = 0;
      repeat (3) @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_period", period, 0);
      check("rst_high", high, 0);
      check("rst_ovf", ovf, 0);
      check("rst_drop", drop, 0);
      check("rst_busy", busy, 0);
      check("rst_busy8", busy8, 0);
      rst = 0;
      mon_en = 1;

      // 30 high / 70 low, exact counts
      r0 = nres;
      start(0, 0);
      drive(0, 10);
      repeat (4) begin drive(1, 30); drive(0, 70); end
      drive(1, 30); drive(0, 10);
      check("count_100_30", nres - r0, 4);
      check("last_period_100", period, 100);
      check("last_high_30", high, 30);

      // prescaler 3, then inverted polarity on the same waveform
      r0 = nres;
      start(3, 0);
      drive(0, 10);
      repeat (3) begin drive(1, 40); drive(0, 60); end
      drive(1, 40); drive(0, 10);
      check("count_presc", nres - r0, 3);
      check("presc_period_25", period, 25);
      check("presc_high_10", high, 10);
      r0 = nres;
      start(3, 1);
      drive(0, 10);
      repeat (3) begin drive(1, 60); drive(0, 40); end
      drive(1, 60); drive(0, 10);
      check("count_pol", nres - r0, 3);
      check("pol_period_25", period, 25);
      check("pol_high_15", high, 15);

      // signal already active at enable: first period must be complete
      r0 = nres;
      live = 0; en = 0; m_presc = 0; m_pol = 0; presc_i = 0; pol_i = 0;
      drive(1, S + 6);
      en = 1;
      model_arm();
      drive(1, 20); drive(0, 20); drive(1, 30); drive(0, 30); drive(1, 10); drive(0, 10);
      check("count_active_at_en", nres - r0, 1);
      check("active_at_en_period", period, 60);

      // randomized waveforms with config scrambled while enabled
      d0 = drop_cnt;
      for (int t = 0; t < 5; t++) begin
         start(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         drive(0, 10);
         for (int k = 0; k < 8; k++) begin
            drive(1, int'($urandom_range(1, 50)));
            pol_i   = 1'($urandom);
            presc_i = 8'($urandom);
            drive(0, int'($urandom_range(1, 50)));
         end
         drive(1, 5);
         drive(0, 10);
      end
      check("rand_queue_empty", q.size(), 0);
      check("rand_no_drop", drop_cnt - d0, 0);

      // back-pressure: hold first, drop second, load third on handshake
      mon_en = 0;
      start(0, 0);
      live = 0; ready = 0; d0 = drop_cnt;
      drive(0, 10);
      drive(1, 10); drive(0, 10);
      n = cyc; drive(1, 0);
      at_cyc(n + S + 2);
      check("hs_first_valid", valid, 1);
      check("hs_first_period", period, 20);
      check("hs_first_high", high, 10);
      at_cyc(n + 5); drive(0, 12);
      n = cyc; drive(1, 0);
      at_cyc(n + S + 2);
      check("hs_drop_pulse", drop, 1);
      check("hs_held_valid", valid, 1);
      check("hs_held_period", period, 20);
      check("hs_held_high", high, 10);
      at_cyc(n + S + 3);
      check("hs_drop_one_cycle", drop, 0);
      at_cyc(n + 7); drive(0, 15);
      n = cyc; drive(1, 0);
      at_cyc(n + S + 1);
      ready = 1;
      at_cyc(n + S + 2);
      check("hs_third_valid", valid, 1);
      check("hs_third_period", period, 22);
      check("hs_third_high", high, 7);
      check("hs_third_no_drop", drop, 0);
      at_cyc(n + S + 3);
      check("hs_valid_drops", valid, 0);
      check("hs_drop_count", drop_cnt - d0, 1);
      drive(0, 10);

      // disable mid-HIGH with a result pending
      start(0, 0);
      live = 0; ready = 0;
      drive(0, 10); drive(1, 10); drive(0, 10); drive(1, 10);
      check("dis_pending", valid, 1);
      en = 0;
      @(negedge clk);
      check("dis_busy", busy, 0);
      check("dis_valid_kept", valid, 1);
      check("dis_period_kept", period, 20);
      check("dis_high_kept", high, 10);
      ready = 1;
      @(negedge clk);
      check("dis_accepted", valid, 0);

      // reset with result pending and measurement running
      start(0, 0);
      live = 0; ready = 0;
      drive(0, 10); drive(1, 10); drive(0, 10); drive(1, 10);
      check("rst2_pending", valid, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("rst2_valid", valid, 0);
      check("rst2_period", period, 0);
      check("rst2_busy", busy, 0);
      drive(0, 10);
      check("rst2_quiet", valid, 0);
      ready = 1;
      en = 0;

      // overflow on the 8-bit instance: stuck active after arming
      en8 = 1;
      repeat (10) @(negedge clk);
      n = cyc; sig8 = 1;
      at_cyc(n + S + 257);
      check("ovf_not_yet", ovf8, 0);
      at_cyc(n + S + 258);
      check("ovf_set", ovf8, 1);
      check("ovf_busy_arm", busy8, 1);
      check("ovf_no_valid", valid8, 0);
      clr8 = 1;
      at_cyc(n + S + 259);
      clr8 = 0;
      check("ovf_cleared", ovf8, 0);
      check("ovf_still_arm", busy8, 1);
      sig8 = 0;
      repeat (10) @(negedge clk);
      n = cyc; sig8 = 1; clr8 = 1;
      at_cyc(n + S + 258);
      check("ovf_set_wins", ovf8, 1);
      at_cyc(n + S + 259);
      check("ovf_clr_after", ovf8, 0);
      clr8 = 0;
      check("ovf_never_valid", valid8, 0);
      check("ovf_no_drop", drop8, 0);
      check("ovf_period_zero", period8, 0);
      check("ovf_high_zero", high8, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/adv_timer_capture.md
ADV_TIMER_CAPTURE -- requirements
Module: adv_timer_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of measurement counter and results.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on signal_i (minimum 2).
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 SHALL have port clk_i  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_en_i  in  1  capture enable.
REQ-007 SHALL have port cfg_pol_i  in  1  0: active level high; 1: signal inverted after synchronizer.
REQ-008 SHALL have port cfg_presc_i  in  8  tick divider; one count per (cfg_presc_i+1) cycles.
REQ-009 SHALL have port signal_i  in  1  asynchronous PWM input (typ. a timer pwm_o line).
REQ-010 SHALL have port meas_ready_i  in  1  consumer accepts result.
REQ-011 SHALL have port meas_valid_o  out  1  result available.
REQ-012 SHALL have port meas_period_o  out  CNT_W  ticks between consecutive active edges.
REQ-013 SHALL have port meas_high_o  out  CNT_W  ticks signal held active within that period.
REQ-014 SHALL have port ovf_o  out  1  sticky counter-overflow flag.
REQ-015 SHALL have port ovf_clr_i  in  1  clears ovf_o.
REQ-016 SHALL have port drop_o  out  1  one-cycle pulse: completed result discarded.
REQ-017 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL pass signal_i through SYNC_STAGES flops, apply cfg_pol_i, then register once for edge detect; detection latency SYNC_STAGES+1 cycles.
REQ-019 SHALL implement states IDLE, ARM, HIGH, LOW.
REQ-020 IDLE: cfg_en_i=1 -> ARM next cycle; cfg_pol_i and cfg_presc_i sampled into internal registers on this transition; changes while enabled ignored.
REQ-021 ARM: rising active edge accepted only after the inactive level has been seen for >=1 cycle in ARM; accepted edge -> HIGH, counters cleared.
REQ-022 HIGH: detected falling edge -> LOW, current tick count captured as high time.
REQ-023 LOW: detected rising edge -> result published, counters cleared, -> HIGH (back-to-back periods measured continuously).
REQ-024 Results SHALL equal floor(C/(presc+1)) where C = cycles between the detected edges (period: rising-to-rising; high: rising-to-falling); presc=0 gives exact cycle counts.
REQ-025 Tick counter reaching 2^CNT_W-1 and receiving another tick: ovf_o set, measurement abandoned, -> ARM; no result published.
REQ-026 cfg_en_i=0 in any state: -> IDLE next cycle, in-progress measurement discarded, pending output result retained.
REQ-027 meas_valid_o SHALL assert the cycle after the closing rising edge is detected (SYNC_STAGES+2 cycles after signal_i rises).
REQ-028 meas_period_o/meas_high_o SHALL stay stable while meas_valid_o=1 and meas_ready_i=0.
REQ-029 Handshake completes on meas_valid_o & meas_ready_i; meas_valid_o drops next cycle unless a new result loads.
REQ-030 New result while valid & !ready: new result discarded, old kept, drop_o pulses 1 cycle.
REQ-031 New result in same cycle as completing handshake: new result loaded, meas_valid_o stays 1, no drop_o.
REQ-032 ovf_o set and ovf_clr_i in same cycle: set wins.

Reset
REQ-033 rst_i=1: state IDLE, synchronizer/edge flops 0, counters 0, meas_valid_o=0, meas_period_o=0, meas_high_o=0, ovf_o=0, drop_o=0, busy_o=0.
REQ-034 rst_i mid-measurement or with result pending SHALL discard everything; no output activity until re-armed.

Verification
REQ-035 presc=0, pol=0, signal 30 cycles high/70 low, ready=1 -> from 2nd rising edge each result period=100, high=30, valid 1 cycle each.
REQ-036 presc=3, signal 40 high/60 low -> period=25, high=10; pol=1 same waveform -> high=15.
REQ-037 CNT_W=8, presc=0, signal stuck high after arming -> ovf_o=1 after 256 ticks, state ARM, no valid; ovf_clr_i pulse -> ovf_o=0.
REQ-038 ready=0, two periods complete -> first result held, drop_o pulses once at second; ready=1 same cycle as third result -> third loaded, no drop.
REQ-039 signal_i high when cfg_en_i rises -> no result until a low then rising edge; first valid only after a full period.
REQ-040 cfg_en_i=0 mid-HIGH with result pending -> busy_o=0 next cycle, pending result still valid and accepted on ready.
